imm_decode_stage: RTL and testbench

Decode-stage controller that sequences the immediate extender between fetch and execute. Each accepted instruction is classified by opcode/funct3 into an immediate type, the extender is driven with that type and `instr[31:7]`, and the sign-extended immediate is registered with the PC behind a valid/ready handshake. The stage supports back-pressure and a pipeline flush from branch resolution.

---
 rtl/core_pkg.sv | 31 +++
 rtl/extend.sv | 26 ++
 rtl/imm_decode_stage.sv | 164 ++++++++++++++++
 tb/tb_imm_decode_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared decode definitions: immediate type codes, RV32I opcodes and the
// decode payload carried by the output register and the skid entry.
package core_pkg;

  localparam logic [2:0] IMM_NONE  = 3'b000;
  localparam logic [2:0] IMM_SHAMT = 3'b001;
  localparam logic [2:0] IMM_I     = 3'b010;
  localparam logic [2:0] IMM_S     = 3'b011;
  localparam logic [2:0] IMM_B     = 3'b100;
  localparam logic [2:0] IMM_U     = 3'b101;
  localparam logic [2:0] IMM_J     = 3'b110;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  immCntrl;
    logic        illegal;
  } decode_t;

endpackage

// File: rtl/extend.sv
// Combinational RV32I immediate extender; instrHi is instr[31:7], so
// instr[k] lives at instrHi[k-7].
import core_pkg::*;

module extend (
  input  logic [24:0] instrHi,
  input  logic [2:0]  immCntrl,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (immCntrl)
      IMM_SHAMT: imm = {27'b0, instrHi[17:13]};
      IMM_I:     imm = {{20{instrHi[24]}}, instrHi[24:13]};
      IMM_S:     imm = {{20{instrHi[24]}}, instrHi[24:18], instrHi[4:0]};
      IMM_B:     imm = {{19{instrHi[24]}}, instrHi[24], instrHi[0],
                        instrHi[23:18], instrHi[4:1], 1'b0};
      IMM_U:     imm = {instrHi[24:5], 12'b0};
      IMM_J:     imm = {{11{instrHi[24]}}, instrHi[24], instrHi[12:5],
                        instrHi[13], instrHi[23:14], 1'b0};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode stage: classifies the immediate type, extends it and registers the
// result behind valid/ready. IMM_DECODE_SKID_EN adds a one-entry skid buffer.
import core_pkg::*;

module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            inValid,
  output logic            inReady,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            outValid,
  input  logic            outReady,
  output logic [31:0]     outInstr,
  output logic [XLEN-1:0] outPc,
  output logic [31:0]     outImm,
  output logic [2:0]      outImmCntrl,
  output logic            outIllegal
);

`ifdef IMM_DECODE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1} state_t;
`endif

  state_t      state_reg, state_next;
  decode_t     out_reg;
  decode_t     dec_in;
  logic [2:0]  imm_cntrl;
  logic        illegal;
  logic [31:0] ext_imm;
  logic        in_fire, out_fire, load_out;

  always_comb begin
    imm_cntrl = IMM_NONE;
    illegal   = 1'b0;
    case (instr[6:0])
      OPC_OP_IMM: imm_cntrl = (instr[13:12] == 2'b01) ? IMM_SHAMT : IMM_I;
      OPC_LOAD, OPC_JALR: imm_cntrl = IMM_I;
      OPC_STORE:  imm_cntrl = IMM_S;
      OPC_BRANCH: imm_cntrl = IMM_B;
      OPC_LUI, OPC_AUIPC: imm_cntrl = IMM_U;
      OPC_JAL:    imm_cntrl = IMM_J;
      OPC_OP:     imm_cntrl = IMM_NONE;
      default:    illegal   = 1'b1;
    endcase
  end

  extend u_extend (
    .instrHi (instr[31:7]),
    .immCntrl(imm_cntrl),
    .imm     (ext_imm)
  );

  always_comb begin
    dec_in.instr    = instr;
    dec_in.pc       = pc;
    dec_in.imm      = ext_imm;
    dec_in.immCntrl = imm_cntrl;
    dec_in.illegal  = illegal;
  end

  assign outValid = (state_reg != EMPTY);
  assign in_fire  = inValid && inReady;
  assign out_fire = outValid && outReady;

`ifdef IMM_DECODE_SKID_EN
  decode_t skid_reg;
  logic    in_ready_reg, load_skid, out_from_skid;

  assign inReady = in_ready_reg;

  always_comb begin
    state_next    = state_reg;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (in_fire) begin
          state_next = FULL;
          load_out   = 1'b1;
        end
        FULL: begin
          if (in_fire && out_fire) begin
            load_out = 1'b1;
          end else if (out_fire) begin
            state_next = EMPTY;
          end else if (in_fire) begin
            state_next = SKID;
            load_skid  = 1'b1;
          end
        end
        SKID: if (out_fire) begin
          state_next    = FULL;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg    <= EMPTY;
      out_reg      <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != SKID);
      if (load_out) out_reg <= out_from_skid ? skid_reg : dec_in;
      if (load_skid) skid_reg <= dec_in;
    end
  end
`else
  // Ready as soon as the held result leaves, giving full throughput.
  assign inReady = !outValid || outReady;

  always_comb begin
    state_next = state_reg;
    load_out   = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (in_fire) begin
          state_next = FULL;
          load_out   = 1'b1;
        end
        FULL: begin
          if (in_fire) load_out = 1'b1;
          else if (out_fire) state_next = EMPTY;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_reg <= EMPTY;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (load_out) out_reg <= dec_in;
    end
  end
`endif

  assign outInstr    = out_reg.instr;
  assign outPc       = out_reg.pc;
  assign outImm      = out_reg.imm;
  assign outImmCntrl = out_reg.immCntrl;
  assign outIllegal  = out_reg.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed cases plus randomized
// traffic against a queue-based reference model (honours IMM_DECODE_SKID_EN).
`timescale 1ns/1ps
module tb_imm_decode_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rstN, inValid, inReady, flush, outValid, outReady, outIllegal;
  logic [31:0] instr, pc, outInstr, outPc, outImm;
  logic [2:0]  outImmCntrl;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  cntrl;
    logic        ill;
  } exp_t;

  exp_t q[$];
  logic [6:0] ops[10] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                          7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0010011};

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .instr(instr), .pc(pc), .flush(flush), .outValid(outValid),
    .outReady(outReady), .outInstr(outInstr), .outPc(outPc),
    .outImm(outImm), .outImmCntrl(outImmCntrl), .outIllegal(outIllegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Reference decode written from the immediate field layouts with masks/shifts.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p);
    exp_t e;
    logic [31:0] sx;
    logic [2:0] f3;
    sx = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    f3 = ins[14:12];
    e.instr = ins; e.pc = p; e.imm = 32'h0; e.cntrl = 3'd0; e.ill = 1'b0;
    case (ins[6:0])
      7'b0010011: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.cntrl = 3'd1; e.imm = (ins >> 20) & 32'h1F;
        end else begin
          e.cntrl = 3'd2; e.imm = 32'($signed(ins) >>> 20);
        end
      end
      7'b0000011, 7'b1100111: begin e.cntrl = 3'd2; e.imm = 32'($signed(ins) >>> 20); end
      7'b0100011: begin
        e.cntrl = 3'd3;
        e.imm = (32'($signed(ins) >>> 20) & ~32'h1F) | ((ins >> 7) & 32'h1F);
      end
      7'b1100011: begin
        e.cntrl = 3'd4;
        e.imm = (sx & 32'hFFFF_F000) | (32'(ins[7]) << 11) |
                (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
      end
      7'b0110111, 7'b0010111: begin e.cntrl = 3'd5; e.imm = ins & 32'hFFFF_F000; end
      7'b1101111: begin
        e.cntrl = 3'd6;
        e.imm = (sx & 32'hFFF0_0000) | (ins & 32'h000F_F000) |
                (32'(ins[20]) << 11) | (((ins >> 21) & 32'h3FF) << 1);
      end
      7'b0110011: e.cntrl = 3'd0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // One clock: drive, check at negedge against the model, advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic ordy, input logic fl);
    logic exp_ready;
    inValid = v; instr = ins; pc = p; outReady = ordy; flush = fl;
    @(negedge clk);
`ifdef IMM_DECODE_SKID_EN
    exp_ready = (q.size() < 2);
`else
    exp_ready = (q.size() == 0) || ordy;
`endif
    check("outValid", 32'(outValid), 32'(q.size() > 0));
    check("inReady", 32'(inReady), 32'(exp_ready));
    if (q.size() > 0) begin
      check("outInstr", outInstr, q[0].instr);
      check("outPc", outPc, q[0].pc);
      check("outImm", outImm, q[0].imm);
      check("outImmCntrl", 32'(outImmCntrl), 32'(q[0].cntrl));
      check("outIllegal", 32'(outIllegal), 32'(q[0].ill));
    end
    $display("cyc in=%0b/%0b instr=%h out=%0b/%0b imm=%h flush=%0b",
             v, inReady, ins, outValid, ordy, outImm, fl);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && exp_ready) q.push_back(ref_decode(ins, p));
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 9)];
    return ins;
  endfunction

  initial begin
    rstN = 1'b0; inValid = 1'b0; instr = '0; pc = '0; flush = 1'b0; outReady = 1'b0;
    #2;
    check("rst_outValid", 32'(outValid), 32'd0);
    check("rst_inReady", 32'(inReady), 32'd1);
    check("rst_outImm", outImm, 32'd0);
    check("rst_outInstr", outInstr, 32'd0);
    check("rst_cntrl", 32'(outImmCntrl), 32'd0);
    @(negedge clk); rstN = 1'b1;
    @(posedge clk); #1;

    // Directed immediates with known constants.
    step(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    check("addi_imm", outImm, 32'hFFFF_FFFF);
    check("addi_cntrl", 32'(outImmCntrl), 32'd2);
    check("addi_pc", outPc, 32'h100);
    step(1'b1, 32'h00509093, 32'h104, 1'b1, 1'b0);
    check("slli_imm", outImm, 32'h5);
    check("slli_cntrl", 32'(outImmCntrl), 32'd1);
    step(1'b1, 32'h12345137, 32'h108, 1'b1, 1'b0);
    check("lui_imm", outImm, 32'h1234_5000);
    check("lui_cntrl", 32'(outImmCntrl), 32'd5);
    step(1'b1, 32'hFE000EE3, 32'h10C, 1'b1, 1'b0);
    check("beq_imm", outImm, 32'hFFFF_FFFC);
    check("beq_cntrl", 32'(outImmCntrl), 32'd4);
    step(1'b1, 32'h0080006F, 32'h110, 1'b1, 1'b0);
    check("jal_imm", outImm, 32'h8);
    check("jal_cntrl", 32'(outImmCntrl), 32'd6);
    step(1'b1, 32'h0000007F, 32'h114, 1'b1, 1'b0);
    check("ill_flag", 32'(outIllegal), 32'd1);
    check("ill_imm", outImm, 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: two pushes while stalled, then release.
    step(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while full (and skid-full when present) with an incoming instruction.
    step(1'b1, 32'h00A00293, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00B00313, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h00C00393, 32'h308, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("flush_outValid", 32'(outValid), 32'd0);
    check("flush_inReady", 32'(inReady), 32'd1);

    // Asynchronous reset in the middle of a stall.
    step(1'b1, 32'hABC00413, 32'h400, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 rstN = 1'b0;
    #1;
    check("arst_outValid", 32'(outValid), 32'd0);
    check("arst_outImm", outImm, 32'd0);
    check("arst_outInstr", outInstr, 32'd0);
    check("arst_outPc", outPc, 32'd0);
    check("arst_inReady", 32'(inReady), 32'd1);
    q.delete();
    @(negedge clk); rstN = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h7FF00493, 32'h500, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
